// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and opcode decode for the multi-cycle RV32I control FSM.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} mc_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    ILLEGAL = 2'd1,
    TIMEOUT = 2'd2
  } trap_cause_t;

  typedef enum logic [2:0] {R, IALU, LOAD, STORE, BRANCH} instr_class_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_t;

  typedef struct packed {
    logic         legal;
    instr_class_t cls;
  } decode_t;

  function automatic decode_t decode_opcode(input logic [6:0] op);
    decode_t d;
    d.legal = 1'b1;
    d.cls   = R;
    case (op)
      OP_R:      d.cls = R;
      OP_IALU:   d.cls = IALU;
      OP_LOAD:   d.cls = LOAD;
      OP_STORE:  d.cls = STORE;
      OP_BRANCH: d.cls = BRANCH;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory request port of the multi-cycle core.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_w;
  logic mem_ready;

  modport master (output mem_req, output mem_w, input mem_ready);
  modport slave  (input mem_req, input mem_w, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive stalled memory-request cycles and flags a timeout.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic            waiting;
  logic [TO_W-1:0] wait_cnt;

  assign waiting = req && !ready;
  // Raised during the TIMEOUT_CYC-th stalled cycle, so a ready in that same cycle still wins.
  assign timeout = waiting && (wait_cnt >= LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         wait_cnt <= '0;
    else if (waiting) wait_cnt <= wait_cnt + 1'b1;
    else              wait_cnt <= '0;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// variable-latency memory, counts retired instructions and traps sticky on errors.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_W    = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [6:0]            opcode,
  input  logic                  alu_zero,
  multicycle_ctrl_if.master     mem_port,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic [1:0]            ctrl_ALU_op,
  output logic                  ctrl_ALU_src,
  output logic                  ctrl_reg_w,
  output logic                  ctrl_mem_to_reg,
  output logic                  busy,
  output logic                  trap,
  output trap_cause_t           trap_cause,
  output logic [RETIRE_W-1:0]   retire_count
);
  mc_state_t    state;
  instr_class_t cls;
  decode_t      dec;
  logic         timeout;
  logic         retire;

  assign dec = decode_opcode(opcode);

  mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .req     (mem_port.mem_req),
    .ready   (mem_port.mem_ready),
    .timeout (timeout)
  );

  always_comb begin
    retire = 1'b0;
    case (state)
      EXEC:    retire = (cls == BRANCH);
      MEM:     retire = (cls == STORE) && mem_port.mem_ready;
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cls          <= R;
      trap         <= 1'b0;
      trap_cause   <= NONE;
      retire_count <= '0;
    end else begin
      if (retire) retire_count <= retire_count + 1'b1;
      case (state)
        IDLE: if (run) state <= FETCH;
        FETCH: begin
          if (mem_port.mem_ready) state <= DECODE;
          else if (timeout) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= TIMEOUT;
          end
        end
        DECODE: begin
          if (dec.legal) begin
            cls   <= dec.cls;
            state <= EXEC;
          end else begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= ILLEGAL;
          end
        end
        EXEC: begin
          case (cls)
            BRANCH:      state <= run ? FETCH : IDLE;
            LOAD, STORE: state <= MEM;
            default:     state <= WB;
          endcase
        end
        MEM: begin
          if (mem_port.mem_ready) begin
            if (cls == STORE) state <= run ? FETCH : IDLE;
            else              state <= WB;
          end else if (timeout) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= TIMEOUT;
          end
        end
        WB:      state <= run ? FETCH : IDLE;
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from state and the held class; only mem_ready and alu_zero reach them combinationally.
  always_comb begin
    mem_port.mem_req = 1'b0;
    mem_port.mem_w   = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pc_src           = 1'b0;
    ctrl_ALU_op      = 2'b00;
    ctrl_ALU_src     = 1'b0;
    ctrl_reg_w       = 1'b0;
    ctrl_mem_to_reg  = 1'b0;
    busy             = (state != IDLE) && (state != TRAP);
    case (state)
      FETCH: begin
        mem_port.mem_req = 1'b1;
        ir_we            = mem_port.mem_ready;
        pc_we            = mem_port.mem_ready;
      end
      EXEC: begin
        case (cls)
          R:           ctrl_ALU_op = 2'b10;
          IALU: begin
            ctrl_ALU_op  = 2'b10;
            ctrl_ALU_src = 1'b1;
          end
          LOAD, STORE: ctrl_ALU_src = 1'b1;
          BRANCH: begin
            ctrl_ALU_op = 2'b01;
            pc_we       = alu_zero;
            pc_src      = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_port.mem_req = 1'b1;
        mem_port.mem_w   = (cls == STORE);
      end
      WB: begin
        ctrl_reg_w      = 1'b1;
        ctrl_mem_to_reg = (cls == LOAD);
      end
      default: ;
    endcase
  end
endmodule
